// File: rtl/mainbus_pkg.sv
// Shared types and constants for the mainbus controller slice.
package mainbus_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_ALU     = 2'd1,
    SRC_REGBANK = 2'd2,
    SRC_MEM     = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    OUT
  } state_t;

endpackage

// File: rtl/mainbus_ctrl_rr_arb3.sv
// Combinational 3-way round-robin picker; bit 0 = ALU, 1 = REGBANK, 2 = MEM.
module rr_arb3
  import mainbus_pkg::*;
(
  input  logic [2:0] req,
  input  src_t       last_grant,
  output logic [2:0] grant,
  output src_t       winner
);

  logic [1:0] order [3];

  always_comb begin
    // Search order starts at the source after the last one granted.
    unique case (last_grant)
      SRC_ALU: begin
        order[0] = 2'd1;
        order[1] = 2'd2;
        order[2] = 2'd0;
      end
      SRC_REGBANK: begin
        order[0] = 2'd2;
        order[1] = 2'd0;
        order[2] = 2'd1;
      end
      default: begin
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
      end
    endcase
  end

  always_comb begin
    grant  = '0;
    winner = SRC_NONE;
    for (int k = 0; k < 3; k++) begin
      if (grant == 3'b000 && req[order[k]]) begin
        grant[order[k]] = 1'b1;
        winner          = src_t'(order[k] + 2'd1);
      end
    end
  end

endmodule

// File: rtl/mainbus_ctrl.sv
// Mainbus arbiter, source-select driver and capture stage with a valid/ready output.
module mainbus_ctrl
  import mainbus_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_alu,
  input  logic              req_regbank,
  input  logic              req_mem,
  output logic              sel_alu,
  output logic              sel_regbank,
  output logic              sel_mem,
  input  logic [DATA_W-1:0] bus_data,
  output logic              cap_valid,
  output logic [DATA_W-1:0] cap_data,
  output src_t              cap_src,
  input  logic              cap_ready,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  src_t              winner_q, winner_d;
  src_t              last_grant_q, last_grant_d;
  logic              cap_valid_q, cap_valid_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  src_t              cap_src_q, cap_src_d;
  logic              busy_q, busy_d;

  logic [2:0] req_vec;
  logic [2:0] arb_grant;
  src_t       arb_winner;
  src_t       arb_last;

  assign req_vec = {req_mem, req_regbank, req_alu};
  // On a handshake in OUT the completing source becomes last_grant in the same cycle.
  assign arb_last = (state_q == OUT) ? winner_q : last_grant_q;

  rr_arb3 u_arb (
    .req       (req_vec),
    .last_grant(arb_last),
    .grant     (arb_grant),
    .winner    (arb_winner)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    cap_valid_d  = cap_valid_q;
    cap_data_d   = cap_data_q;
    cap_src_d    = cap_src_q;
    unique case (state_q)
      IDLE: begin
        if (|req_vec) begin
          sel_d    = arb_grant;
          winner_d = arb_winner;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        cap_data_d  = bus_data;
        cap_src_d   = winner_q;
        cap_valid_d = 1'b1;
        sel_d       = '0;
        state_d     = OUT;
      end
      OUT: begin
        if (cap_ready) begin
          last_grant_d = winner_q;
          cap_valid_d  = 1'b0;
          if (|req_vec) begin
            sel_d    = arb_grant;
            winner_d = arb_winner;
            state_d  = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      winner_q     <= SRC_NONE;
      last_grant_q <= SRC_MEM;
      cap_valid_q  <= 1'b0;
      cap_data_q   <= '0;
      cap_src_q    <= SRC_NONE;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      cap_valid_q  <= cap_valid_d;
      cap_data_q   <= cap_data_d;
      cap_src_q    <= cap_src_d;
      busy_q       <= busy_d;
    end
  end

  assign sel_alu     = sel_q[0];
  assign sel_regbank = sel_q[1];
  assign sel_mem     = sel_q[2];
  assign cap_valid   = cap_valid_q;
  assign cap_data    = cap_data_q;
  assign cap_src     = cap_src_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mainbus_ctrl.sv
// Directed bench for mainbus_ctrl; a monitor pops expected words on every output handshake.
module tb_mainbus_ctrl;
  import mainbus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_alu, req_regbank, req_mem;
  logic        sel_alu, sel_regbank, sel_mem;
  logic [31:0] bus_data;
  logic        cap_valid;
  logic [31:0] cap_data;
  src_t        cap_src;
  logic        cap_ready;
  logic        busy;

  logic [31:0] alu_w, reg_w, mem_w, idle_w;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   passes;

  mainbus_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_alu    (req_alu),
    .req_regbank(req_regbank),
    .req_mem    (req_mem),
    .sel_alu    (sel_alu),
    .sel_regbank(sel_regbank),
    .sel_mem    (sel_mem),
    .bus_data   (bus_data),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_src    (cap_src),
    .cap_ready  (cap_ready),
    .busy       (busy)
  );

  // Mainbus mux model.
  assign bus_data = sel_alu ? alu_w : sel_regbank ? reg_w : sel_mem ? mem_w : idle_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_word(input src_t s, input logic [31:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      check("sel_onehot0", {31'b0, $onehot0({sel_mem, sel_regbank, sel_alu})}, 32'd1);
      check("sel_vs_valid", {31'b0, (|{sel_mem, sel_regbank, sel_alu}) & cap_valid}, 32'd0);
      if (rst_n && cap_valid && cap_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_capture", {30'b0, cap_src}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_src", {30'b0, cap_src}, {30'b0, e.src});
          check("sb_data", cap_data, e.data);
        end
      end
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    req_alu = 1'b1; req_regbank = 1'b1; req_mem = 1'b1;
    cap_ready = 1'b0;
    alu_w = '0; reg_w = '0; mem_w = '0; idle_w = '0;

    // Reset held with all requests active.
    repeat (3) @(negedge clk);
    check("rst_sel", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd0);
    check("rst_valid", {31'b0, cap_valid}, 32'd0);
    check("rst_data", cap_data, 32'd0);
    check("rst_src", {30'b0, cap_src}, {30'b0, SRC_NONE});
    check("rst_busy", {31'b0, busy}, 32'd0);

    // Single ALU transfer.
    rst_n = 1'b1;
    req_alu = 1'b0; req_regbank = 1'b0; req_mem = 1'b0;
    cap_ready = 1'b1;
    alu_w = 32'hDEAD_BEEF;
    @(negedge clk);
    req_alu = 1'b1;
    expect_word(SRC_ALU, 32'hDEAD_BEEF);
    @(negedge clk);
    req_alu = 1'b0;
    check("single_sel_on", {31'b0, sel_alu}, 32'd1);
    check("single_valid_early", {31'b0, cap_valid}, 32'd0);
    check("single_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("single_sel_off", {31'b0, sel_alu}, 32'd0);
    check("single_valid", {31'b0, cap_valid}, 32'd1);
    check("single_data", cap_data, 32'hDEAD_BEEF);
    check("single_src", {30'b0, cap_src}, {30'b0, SRC_ALU});
    @(negedge clk);
    check("single_done_valid", {31'b0, cap_valid}, 32'd0);
    check("single_done_busy", {31'b0, busy}, 32'd0);

    // Backpressure: REGBANK word held while MEM waits.
    reg_w = 32'hCAFE_F00D;
    mem_w = 32'h0000_0333;
    cap_ready = 1'b0;
    req_regbank = 1'b1;
    expect_word(SRC_REGBANK, 32'hCAFE_F00D);
    @(negedge clk);
    check("bp_sel_reg", {31'b0, sel_regbank}, 32'd1);
    req_regbank = 1'b0;
    req_mem = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, cap_valid}, 32'd1);
      check("bp_data", cap_data, 32'hCAFE_F00D);
      check("bp_src", {30'b0, cap_src}, {30'b0, SRC_REGBANK});
      check("bp_no_sel", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd0);
    end
    cap_ready = 1'b1;
    expect_word(SRC_MEM, 32'h0000_0333);
    @(negedge clk);
    check("bp_sel_mem", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd4);
    check("bp_valid_low", {31'b0, cap_valid}, 32'd0);
    req_mem = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_idle_busy", {31'b0, busy}, 32'd0);

    // Fairness: all three held, expected order ALU, REGBANK, MEM, ALU.
    alu_w = 32'h1; reg_w = 32'h2; mem_w = 32'h3;
    expect_word(SRC_ALU, 32'h1);
    expect_word(SRC_REGBANK, 32'h2);
    expect_word(SRC_MEM, 32'h3);
    expect_word(SRC_ALU, 32'h1);
    req_alu = 1'b1; req_regbank = 1'b1; req_mem = 1'b1;
    repeat (7) @(negedge clk);
    req_alu = 1'b0; req_regbank = 1'b0; req_mem = 1'b0;
    repeat (3) @(negedge clk);
    check("fair_drained", sb.size(), 32'd0);
    check("fair_idle_busy", {31'b0, busy}, 32'd0);

    // Reset during DRIVE discards the transfer and restores ALU-first priority.
    req_regbank = 1'b1;
    @(negedge clk);
    check("mid_sel_reg", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd2);
    rst_n = 1'b0;
    req_regbank = 1'b0;
    @(negedge clk);
    check("mid_sel", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd0);
    check("mid_valid", {31'b0, cap_valid}, 32'd0);
    check("mid_data", cap_data, 32'd0);
    check("mid_src", {30'b0, cap_src}, {30'b0, SRC_NONE});
    check("mid_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    alu_w = 32'h0000_0A1A;
    req_alu = 1'b1;
    req_regbank = 1'b1;
    expect_word(SRC_ALU, 32'h0000_0A1A);
    @(negedge clk);
    check("mid_alu_first", {29'b0, sel_mem, sel_regbank, sel_alu}, 32'd1);
    req_alu = 1'b0;
    req_regbank = 1'b0;
    repeat (3) @(negedge clk);

    // Idle bus with a nonzero undriven value is never captured.
    idle_w = 32'h5555_5555;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_valid", {31'b0, cap_valid}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);
    end

    check("final_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
